video_stream_sink: RTL and testbench

Avalon-ST video sink that consumes the 30-bit pixel stream produced by the GPU's stream master (SOP/EOP framed, Avalon-ST Video packet types). It recovers pixel coordinates, discards non-video packets, and checks frame geometry against the configured screen size. It re-emits each video pixel with its (x, y) position on a registered valid/ready port. It is the receiving end for loopback verification and for frame capture into memory.

---
 rtl/video_stream_sink.sv | 239 +++++++++++++++++++++++
 tb/tb_video_stream_sink.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_sink.sv
// video_stream_sink
//   Avalon-ST video sink. Consumes SOP/EOP framed packets, keeps type-0
//   (video) packets, recovers the (x, y) position of every pixel and checks
//   frame geometry against SCREEN_X_SIZE x SCREEN_Y_SIZE. Each video pixel is
//   re-emitted with its coordinates on a registered valid/ready port.
//
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   s_*               : Avalon-ST sink (data, sop, eop, empty(ignored), valid, ready)
//   pix_*             : pixel output (data, x, y, valid, ready)
//   frame_done        : one-cycle pulse per well-formed frame
//   frame_count       : well-formed frames since reset (wraps)
//   err_pulse         : [0] early SOP, [1] short frame, [2] long frame
//   err_sticky        : OR-accumulated err_pulse, cleared by clear_err
//   frame_sig         : pixel signature of the last good frame
//
// Configuration
//   VIDEO_SINK_SIG_EN : when defined, a rotate-xor signature over the pixels
//                       of each good frame is reported on frame_sig;
//                       otherwise frame_sig is constant 0.

module video_stream_sink #(
  parameter int COORD_WIDTH   = 16,
  parameter int SCREEN_X_SIZE = 800,
  parameter int SCREEN_Y_SIZE = 600,
  parameter int DATA_WIDTH    = 30
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_startofpacket,
  input  logic                   s_endofpacket,
  input  logic                   s_empty,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [DATA_WIDTH-1:0]  pix_data,
  output logic [COORD_WIDTH-1:0] pix_x,
  output logic [COORD_WIDTH-1:0] pix_y,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   frame_done,
  output logic [31:0]            frame_count,
  output logic [2:0]             err_pulse,
  output logic [2:0]             err_sticky,
  input  logic                   clear_err,
  output logic [31:0]            frame_sig
);

  typedef enum logic [1:0] {
    WAIT_SOP = 2'd0,
    VIDEO    = 2'd1,
    SKIP     = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(SCREEN_X_SIZE - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(SCREEN_Y_SIZE - 1);

  state_t                 state_r, state_nxt_s;
  logic [COORD_WIDTH-1:0] x_r, y_r, x_nxt_s, y_nxt_s;
  logic                   accept_s, load_pix_s, done_s, last_pix_s;
  logic [2:0]             err_s;

  logic [DATA_WIDTH-1:0]  pix_data_r;
  logic [COORD_WIDTH-1:0] pix_x_r, pix_y_r;
  logic                   pix_valid_r, frame_done_r;
  logic [31:0]            frame_count_r;
  logic [2:0]             err_pulse_r, err_sticky_r;

  // s_empty carries no information for a single-symbol stream.
  logic unused_empty_s;
  assign unused_empty_s = s_empty;

  // Ready is held low throughout reset; otherwise the output register can
  // take a new beat whenever it is empty or being drained this cycle.
  assign s_ready    = !rst && (!pix_valid_r || pix_ready);
  assign accept_s   = s_valid && s_ready;
  assign last_pix_s = (x_r == X_LAST) && (y_r == Y_LAST);

  // Next-state, coordinate and strobe decode for one accepted beat.
  always_comb begin
    state_nxt_s = state_r;
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    load_pix_s  = 1'b0;
    done_s      = 1'b0;
    err_s       = 3'b000;
    if (accept_s) begin
      if (s_startofpacket) begin
        // SOP always restarts header decode; only an open video packet
        // (VIDEO or DRAIN) being cut short counts as an error.
        if ((state_r == VIDEO) || (state_r == DRAIN)) begin
          err_s[0] = 1'b1;
        end else begin
          err_s[0] = 1'b0;
        end
        if (s_endofpacket) begin
          state_nxt_s = WAIT_SOP;
        end else if (s_data[3:0] == 4'd0) begin
          state_nxt_s = VIDEO;
          x_nxt_s     = {COORD_WIDTH{1'b0}};
          y_nxt_s     = {COORD_WIDTH{1'b0}};
        end else begin
          state_nxt_s = SKIP;
        end
      end else begin
        case (state_r)
          WAIT_SOP: begin
            state_nxt_s = WAIT_SOP;
          end
          VIDEO: begin
            load_pix_s = 1'b1;
            if (s_endofpacket) begin
              state_nxt_s = WAIT_SOP;
              if (last_pix_s) begin
                done_s = 1'b1;
              end else begin
                err_s[1] = 1'b1;
              end
            end else if (last_pix_s) begin
              err_s[2]    = 1'b1;
              state_nxt_s = DRAIN;
            end else if (x_r == X_LAST) begin
              x_nxt_s = {COORD_WIDTH{1'b0}};
              y_nxt_s = y_r + COORD_WIDTH'(1);
            end else begin
              x_nxt_s = x_r + COORD_WIDTH'(1);
            end
          end
          SKIP, DRAIN: begin
            if (s_endofpacket) begin
              state_nxt_s = WAIT_SOP;
            end else begin
              state_nxt_s = state_r;
            end
          end
          default: begin
            state_nxt_s = WAIT_SOP;
          end
        endcase
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state and coordinate counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= WAIT_SOP;
      x_r     <= {COORD_WIDTH{1'b0}};
      y_r     <= {COORD_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      x_r     <= x_nxt_s;
      y_r     <= y_nxt_s;
    end
  end

  // Pixel output register: loads on an accepted pixel, empties on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_data_r  <= {DATA_WIDTH{1'b0}};
      pix_x_r     <= {COORD_WIDTH{1'b0}};
      pix_y_r     <= {COORD_WIDTH{1'b0}};
      pix_valid_r <= 1'b0;
    end else if (load_pix_s) begin
      pix_data_r  <= s_data;
      pix_x_r     <= x_r;
      pix_y_r     <= y_r;
      pix_valid_r <= 1'b1;
    end else if (pix_ready) begin
      pix_valid_r <= 1'b0;
    end
  end

  // Frame status: done pulse, frame counter, error strobes and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done_r  <= 1'b0;
      frame_count_r <= 32'd0;
      err_pulse_r   <= 3'b000;
      err_sticky_r  <= 3'b000;
    end else begin
      frame_done_r  <= done_s;
      frame_count_r <= done_s ? (frame_count_r + 32'd1) : frame_count_r;
      err_pulse_r   <= err_s;
      // A clear and a new error in the same cycle leave the new error set.
      err_sticky_r  <= (clear_err ? 3'b000 : err_sticky_r) | err_s;
    end
  end

  assign pix_data    = pix_data_r;
  assign pix_x       = pix_x_r;
  assign pix_y       = pix_y_r;
  assign pix_valid   = pix_valid_r;
  assign frame_done  = frame_done_r;
  assign frame_count = frame_count_r;
  assign err_pulse   = err_pulse_r;
  assign err_sticky  = err_sticky_r;

`ifdef VIDEO_SINK_SIG_EN
  logic [31:0] sig_r, sig_nxt_s, frame_sig_r;

  // One signature step: rotate left by one, fold in the zero-extended pixel.
  function automatic logic [31:0] sig_step(input logic [31:0] sig,
                                           input logic [DATA_WIDTH-1:0] d);
    return {sig[30:0], sig[31]} ^ 32'(d);
  endfunction

  // Running signature: cleared by a video header, stepped per emitted pixel.
  always_comb begin
    sig_nxt_s = sig_r;
    if (accept_s && s_startofpacket && !s_endofpacket && (s_data[3:0] == 4'd0)) begin
      sig_nxt_s = 32'd0;
    end else if (load_pix_s) begin
      sig_nxt_s = sig_step(sig_r, s_data);
    end else begin
      sig_nxt_s = sig_r;
    end
  end

  // Signature registers; frame_sig only captures frames that close cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_r       <= 32'd0;
      frame_sig_r <= 32'd0;
    end else begin
      sig_r       <= sig_nxt_s;
      frame_sig_r <= done_s ? sig_nxt_s : frame_sig_r;
    end
  end

  assign frame_sig = frame_sig_r;
`else
  assign frame_sig = 32'd0;
`endif

endmodule

// File: tb/tb_video_stream_sink.sv
module tb_video_stream_sink;

  localparam int CW = 16;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = 30;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_startofpacket = 1'b0;
  logic          s_endofpacket = 1'b0;
  logic          s_empty = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] pix_data;
  logic [CW-1:0] pix_x, pix_y;
  logic          pix_valid;
  logic          pix_ready = 1'b1;
  logic          frame_done;
  logic [31:0]   frame_count;
  logic [2:0]    err_pulse, err_sticky;
  logic          clear_err = 1'b0;
  logic [31:0]   frame_sig;

  video_stream_sink #(
    .COORD_WIDTH(CW), .SCREEN_X_SIZE(W), .SCREEN_Y_SIZE(H), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_startofpacket(s_startofpacket),
    .s_endofpacket(s_endofpacket), .s_empty(s_empty), .s_valid(s_valid),
    .s_ready(s_ready), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .frame_done(frame_done),
    .frame_count(frame_count), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .clear_err(clear_err), .frame_sig(frame_sig)
  );

  always #5 clk = ~clk;

`ifdef VIDEO_SINK_SIG_EN
  localparam logic [31:0] SIG_ONES = 32'h0000_00FF;
`else
  localparam logic [31:0] SIG_ONES = 32'h0000_0000;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int outs  = 0;
  int dones = 0;
  int rmode = 0;
  int ph    = 0;
  bit rand_clr = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Mode: 0 idle, 1 video packet open, 2 non-video packet, 3 overlong video
  int          md = 0;
  int          npx = 0;
  bit          started = 1'b0;
  logic        e_valid = 1'b0;
  logic [DW-1:0] e_data = '0;
  int          e_x = 0, e_y = 0;
  logic        e_done = 1'b0;
  logic [2:0]  e_err = 3'b0, e_sticky = 3'b0;
  logic [31:0] e_count = 32'd0, e_fsig = 32'd0, run_sig = 32'd0;

  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      md = 0; npx = 0; e_valid = 1'b0; e_data = '0; e_x = 0; e_y = 0;
      e_done = 1'b0; e_err = 3'b0; e_sticky = 3'b0; e_count = 32'd0;
      e_fsig = 32'd0; run_sig = 32'd0;
    end else if (started) begin
      bit acc;
      acc = s_valid && (!e_valid || pix_ready);
      e_done = 1'b0;
      e_err = 3'b0;
      if (e_valid && pix_ready) e_valid = 1'b0;
      if (acc) begin
        if (s_startofpacket) begin
          if (md == 1 || md == 3) e_err[0] = 1'b1;
          if (s_endofpacket) md = 0;
          else if (s_data[3:0] == 4'd0) begin md = 1; npx = 0; run_sig = 32'd0; end
          else md = 2;
        end else if (md == 1) begin
          e_valid = 1'b1;
          e_data  = s_data;
          e_x     = npx % W;
          e_y     = npx / W;
          run_sig = {run_sig[30:0], run_sig[31]} ^ {2'b00, s_data};
          npx++;
          if (s_endofpacket) begin
            md = 0;
            if (npx == W * H) begin
              e_done = 1'b1;
              e_count = e_count + 32'd1;
`ifdef VIDEO_SINK_SIG_EN
              e_fsig = run_sig;
`endif
            end else begin
              e_err[1] = 1'b1;
            end
          end else if (npx == W * H) begin
            e_err[2] = 1'b1;
            md = 3;
          end
        end else if (md != 0 && s_endofpacket) begin
          md = 0;
        end
      end
      e_sticky = (clear_err ? 3'b0 : e_sticky) | e_err;
    end
  end

  // Compare process: every output against the model on every falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("s_ready", 64'(s_ready), 64'(!rst && (!e_valid || pix_ready)));
      chk("pix_valid", 64'(pix_valid), 64'(e_valid));
      chk("pix_data", 64'(pix_data), 64'(e_data));
      chk("pix_x", 64'(pix_x), 64'(e_x));
      chk("pix_y", 64'(pix_y), 64'(e_y));
      chk("frame_done", 64'(frame_done), 64'(e_done));
      chk("frame_count", 64'(frame_count), 64'(e_count));
      chk("err_pulse", 64'(err_pulse), 64'(e_err));
      chk("err_sticky", 64'(err_sticky), 64'(e_sticky));
      chk("frame_sig", 64'(frame_sig), 64'(e_fsig));
      if (pix_valid && pix_ready) outs++;
      if (frame_done) dones++;
    end
  end

  // Downstream ready pattern: always, random, or one cycle in three.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: pix_ready = 1'b1;
        1: pix_ready = 1'($urandom_range(0, 1));
        default: begin
          pix_ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      s_valid = 1'b0;
      s_startofpacket = 1'($urandom_range(0, 1));
      s_endofpacket = 1'($urandom_range(0, 1));
      s_data = DW'($urandom);
      clear_err = rand_clr && ($urandom_range(0, 7) == 0);
      @(posedge clk);
      #1;
    end
    clear_err = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input bit sop, input bit eop);
    bit r;
    s_data = d;
    s_startofpacket = sop;
    s_endofpacket = eop;
    s_empty = 1'($urandom_range(0, 1));
    s_valid = 1'b1;
    for (int k = 0; ; k++) begin
      @(negedge clk);
      r = s_ready;
      @(posedge clk);
      #1;
      if (r) break;
      if (k > 500) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat_timeout: got no s_ready expected handshake at %0t", $time);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic pkt(input logic [3:0] typ, input int npix, input bit do_eop,
                     input bit fixed, input logic [DW-1:0] val, input int gapmax);
    logic [DW-1:0] d;
    d = DW'($urandom);
    d[3:0] = typ;
    beat(d, 1'b1, do_eop && (npix == 0));
    for (int i = 0; i < npix; i++) begin
      idle($urandom_range(0, gapmax));
      d = fixed ? val : DW'($urandom);
      beat(d, 1'b0, do_eop && (i == npix - 1));
    end
  endtask

  task automatic settle();
    rmode = 0;
    idle(4);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
  endtask

  initial begin
    int o0, d0;
    idle(3);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_pix_valid", 64'(pix_valid), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    chk("rst_frame_sig", 64'(frame_sig), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;

    // Well-formed frame of ones
    o0 = outs; d0 = dones;
    pkt(4'h0, 8, 1'b1, 1'b1, DW'(1), 0);
    settle();
    chk("wf_outs", 64'(outs - o0), 64'd8);
    chk("wf_dones", 64'(dones - d0), 64'd1);
    chk("wf_count", 64'(frame_count), 64'd1);
    chk("wf_sticky", 64'(err_sticky), 64'd0);
    chk("wf_sig", 64'(frame_sig), 64'(SIG_ONES));

    // Control packet, then another frame of ones
    o0 = outs;
    pkt(4'hF, 3, 1'b1, 1'b0, '0, 1);
    settle();
    chk("ctrl_outs", 64'(outs - o0), 64'd0);
    chk("ctrl_sticky", 64'(err_sticky), 64'd0);
    pkt(4'h0, 8, 1'b1, 1'b1, DW'(1), 1);
    settle();
    chk("ctrl_next_count", 64'(frame_count), 64'd2);

    // Short frame
    o0 = outs;
    pkt(4'h0, 5, 1'b1, 1'b0, '0, 0);
    settle();
    chk("short_outs", 64'(outs - o0), 64'd5);
    chk("short_sticky", 64'(err_sticky), 64'b010);
    chk("short_count", 64'(frame_count), 64'd2);
    chk("short_sig_kept", 64'(frame_sig), 64'(SIG_ONES));
    pulse_clear();
    chk("clear_sticky", 64'(err_sticky), 64'd0);

    // Long frame, then a normal one
    o0 = outs;
    pkt(4'h0, 10, 1'b1, 1'b0, '0, 0);
    settle();
    chk("long_outs", 64'(outs - o0), 64'd8);
    chk("long_sticky", 64'(err_sticky), 64'b100);
    pkt(4'h0, 8, 1'b1, 1'b0, '0, 0);
    settle();
    chk("long_next_count", 64'(frame_count), 64'd3);
    pulse_clear();

    // Early SOP after 3 pixels
    o0 = outs; d0 = dones;
    pkt(4'h0, 3, 1'b0, 1'b0, '0, 0);
    pkt(4'h0, 8, 1'b1, 1'b0, '0, 0);
    settle();
    chk("esop_sticky", 64'(err_sticky), 64'b001);
    chk("esop_outs", 64'(outs - o0), 64'd11);
    chk("esop_dones", 64'(dones - d0), 64'd1);
    chk("esop_count", 64'(frame_count), 64'd4);
    pulse_clear();

    // Backpressure: ready one cycle in three
    o0 = outs;
    rmode = 2;
    pkt(4'h0, 8, 1'b1, 1'b0, '0, 0);
    settle();
    chk("bp_outs", 64'(outs - o0), 64'd8);
    chk("bp_count", 64'(frame_count), 64'd5);

    // Reset in the middle of a frame
    rmode = 1;
    pkt(4'h0, 3, 1'b0, 1'b0, '0, 0);
    rst = 1'b1;
    idle(2);
    chk("mrst_pix_valid", 64'(pix_valid), 64'd0);
    chk("mrst_count", 64'(frame_count), 64'd0);
    chk("mrst_sticky", 64'(err_sticky), 64'd0);
    chk("mrst_s_ready", 64'(s_ready), 64'd0);
    rst = 1'b0;
    pkt(4'h0, 8, 1'b1, 1'b1, DW'(1), 0);
    settle();
    chk("mrst_next_count", 64'(frame_count), 64'd1);
    chk("mrst_next_sticky", 64'(err_sticky), 64'd0);
    chk("mrst_next_sig", 64'(frame_sig), 64'(SIG_ONES));

    // Randomized traffic against the model
    rand_clr = 1'b1;
    for (int p = 0; p < 80; p++) begin
      logic [3:0] typ;
      int np;
      rmode = $urandom_range(0, 2);
      typ = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      np = ($urandom_range(0, 1) == 0) ? 8 : $urandom_range(0, 11);
      pkt(typ, np, ($urandom_range(0, 5) != 0), 1'b0, '0, 2);
      idle($urandom_range(0, 2));
    end
    rand_clr = 1'b0;
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
